sec_ded_decoder_28: RTL and testbench

SEC_DED_DECODER_28 -- requirements
Module: sec_ded_decoder_28

---
 rtl/sec_ded_decoder_28.sv | 170 +++++++++++++++++
 tb/tb_sec_ded_decoder_28.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_ded_decoder_28.sv
// sec_ded_decoder_28: two-stage pipelined SEC-DED decoder for 28 data bits
// protected by 6 Hamming check bits plus one overall parity bit.
// Stage 1 captures the codeword together with its syndrome and parity.
// Stage 2 captures the corrected data and the sec/ded classification.
// Optional error counters are enabled by defining SEC_DED_ERR_CNT_EN;
// without it the counter outputs are constant zero and clr_cnt_i is ignored.

module sec_ded_decoder_28 #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [27:0]      data_i,
  input  logic [6:0]       ecc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [27:0]      data_o,
  output logic [6:0]       syndrome_o,
  output logic             sec_o,
  output logic             ded_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] ce_cnt_o,
  output logic [CNT_W-1:0] ue_cnt_o
);

  // Hamming position of data bit k: the k-th non-power-of-two position from 3 up.
  // Positions 1, 2, 4, 8, 16 and 32 belong to the check bits.
  function automatic logic [5:0] dataPos(input int k);
    int cnt;
    cnt     = 0;
    dataPos = 6'd0;
    for (int p = 3; p < 35; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) dataPos = 6'(p);
        cnt++;
      end
    end
  endfunction

  logic        w_s2Adv;
  logic        w_s1Adv;
  logic [5:0]  w_syn;
  logic        w_par;
  logic [27:0] w_corrData;
  logic        w_sec;
  logic        w_ded;

  logic        r_s1Valid;
  logic [27:0] r_s1Data;
  logic [5:0]  r_s1Syn;
  logic        r_s1Par;

  logic        r_s2Valid;
  logic [27:0] r_s2Data;
  logic [6:0]  r_s2Syn;
  logic        r_s2Sec;
  logic        r_s2Ded;

  // Stage 2 moves whenever its slot is free or being drained; stage 1 follows.
  assign w_s2Adv    = !r_s2Valid || out_ready_i;
  assign w_s1Adv    = !r_s1Valid || w_s2Adv;
  assign in_ready_o = rst_ni && w_s1Adv;

  // Syndrome: received check bits folded with the positions of every set data bit.
  always_comb begin
    w_syn = ecc_i[5:0];
    for (int k = 0; k < 28; k++) begin
      if (data_i[k]) w_syn = w_syn ^ dataPos(k);
    end
  end

  assign w_par = ^{data_i, ecc_i};

  // Stage 1 register: codeword data plus its syndrome and overall parity.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Syn   <= '0;
      r_s1Par   <= 1'b0;
    end else if (w_s1Adv) begin
      r_s1Valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1Data <= data_i;
        r_s1Syn  <= w_syn;
        r_s1Par  <= w_par;
      end
    end
  end

  // Classify the stage-1 codeword and flip the data bit a single error points at.
  // A syndrome naming a check-bit position needs no data correction.
  always_comb begin
    w_corrData = r_s1Data;
    w_sec      = 1'b0;
    w_ded      = 1'b0;
    if (r_s1Syn == 6'd0) begin
      w_sec = r_s1Par;
    end else if (!r_s1Par) begin
      w_ded = 1'b1;
    end else if (r_s1Syn > 6'd34) begin
      w_ded = 1'b1;
    end else begin
      w_sec = 1'b1;
      for (int k = 0; k < 28; k++) begin
        if (dataPos(k) == r_s1Syn) w_corrData[k] = ~r_s1Data[k];
      end
    end
  end

  // Stage 2 register: decoded result, held while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s2Valid <= 1'b0;
      r_s2Data  <= '0;
      r_s2Syn   <= '0;
      r_s2Sec   <= 1'b0;
      r_s2Ded   <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Data <= w_corrData;
        r_s2Syn  <= {r_s1Par, r_s1Syn};
        r_s2Sec  <= w_sec;
        r_s2Ded  <= w_ded;
      end
    end
  end

  assign out_valid_o = r_s2Valid;
  assign data_o      = r_s2Data;
  assign syndrome_o  = r_s2Syn;
  assign sec_o       = r_s2Sec;
  assign ded_o       = r_s2Ded;

`ifdef SEC_DED_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_outHs;
  logic [CNT_W-1:0] r_ceCnt;
  logic [CNT_W-1:0] r_ueCnt;

  assign w_outHs = r_s2Valid && out_ready_i;

  // Saturating error counters, one step per delivered result; clear wins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ceCnt <= '0;
      r_ueCnt <= '0;
    end else if (clr_cnt_i) begin
      r_ceCnt <= '0;
      r_ueCnt <= '0;
    end else if (w_outHs) begin
      if (r_s2Sec && (r_ceCnt != CNT_MAX)) r_ceCnt <= r_ceCnt + CNT_W'(1);
      if (r_s2Ded && (r_ueCnt != CNT_MAX)) r_ueCnt <= r_ueCnt + CNT_W'(1);
    end
  end

  assign ce_cnt_o = r_ceCnt;
  assign ue_cnt_o = r_ueCnt;
`else
  // Counters absent: outputs are constant zero; clr_cnt_i is masked off so it
  // still has a reader but never influences anything.
  assign ce_cnt_o = {CNT_W{clr_cnt_i & 1'b0}};
  assign ue_cnt_o = {CNT_W{clr_cnt_i & 1'b0}};
`endif

endmodule

// File: tb/tb_sec_ded_decoder_28.sv
// tb_sec_ded_decoder_28: bench for sec_ded_decoder_28 with a codeword-level
// reference model, a per-cycle scoreboard and directed literal vectors.
// Counter expectations follow SEC_DED_ERR_CNT_EN when it is defined.

module tb_sec_ded_decoder_28;

  localparam int CW = 4;
`ifdef SEC_DED_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CNT_SAT = (1 << CW) - 1;

  typedef struct {
    logic [27:0] data;
    logic [6:0]  syn;
    logic        sec;
    logic        ded;
    int          acc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          inValid;
  logic          inReady;
  logic [27:0]   dataIn;
  logic [6:0]    eccIn;
  logic          outValid;
  logic          outReady;
  logic [27:0]   dataOut;
  logic [6:0]    synOut;
  logic          secOut;
  logic          dedOut;
  logic          clrCnt;
  logic [CW-1:0] ceCnt;
  logic [CW-1:0] ueCnt;

  int    nChecks = 0;
  int    nFails  = 0;
  int    cyc     = 0;
  bit    armed   = 1'b0;
  int    dataPosTb [28];
  beat_t sbQ [$];
  int    ceExp = 0;
  int    ueExp = 0;
  logic  expValid;
  logic  expReady;
  beat_t front;

  sec_ded_decoder_28 #(.CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .data_i      (dataIn),
    .ecc_i       (eccIn),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .data_o      (dataOut),
    .syndrome_o  (synOut),
    .sec_o       (secOut),
    .ded_o       (dedOut),
    .clr_cnt_i   (clrCnt),
    .ce_cnt_o    (ceCnt),
    .ue_cnt_o    (ueCnt)
  );

  // Free-running clock and cycle counter used to age in-flight beats.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference decode: syndrome is the XOR of the positions of every set bit
  // of the 34-bit Hamming word; parity covers all 35 received bits.
  function automatic beat_t refDecode(input logic [27:0] d, input logic [6:0] e);
    beat_t r;
    int    s;
    logic  p;
    s = 0;
    for (int j = 0; j < 6; j++) if (e[j]) s = s ^ (1 << j);
    for (int k = 0; k < 28; k++) if (d[k]) s = s ^ dataPosTb[k];
    p = ^{d, e};
    r.data = d;
    r.syn  = {p, 6'(s)};
    r.sec  = 1'b0;
    r.ded  = 1'b0;
    r.acc  = 0;
    if (s == 0) r.sec = p;
    else if (!p) r.ded = 1'b1;
    else if (s > 34) r.ded = 1'b1;
    else begin
      r.sec = 1'b1;
      for (int k = 0; k < 28; k++) if (dataPosTb[k] == s) r.data[k] = ~d[k];
    end
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [27:0] d);
    int s;
    s = 0;
    for (int k = 0; k < 28; k++) if (d[k]) s = s ^ dataPosTb[k];
    return {^{d, 6'(s)}, 6'(s)};
  endfunction

  // Scoreboard: compare at mid-cycle, then advance the model for the next edge.
  always @(negedge clk) begin
    expReady = rstN && ((sbQ.size() < 2) || outReady);
    expValid = (sbQ.size() > 0) && ((cyc - sbQ[0].acc) >= 2);
    if (armed) begin
      checkOutput("inReady", inReady, expReady);
      checkOutput("outValid", outValid, expValid);
      if (expValid && outValid) begin
        front = sbQ[0];
        checkOutput("dataOut", dataOut, front.data);
        checkOutput("syndromeOut", synOut, front.syn);
        checkOutput("secOut", secOut, front.sec);
        checkOutput("dedOut", dedOut, front.ded);
      end
      checkOutput("secDedExclusive", secOut & dedOut, 1'b0);
      checkOutput("ceCnt", ceCnt, ceExp);
      checkOutput("ueCnt", ueCnt, ueExp);
    end
    if (!rstN) begin
      sbQ.delete();
      ceExp = 0;
      ueExp = 0;
      armed = 1'b1;
    end else if (armed) begin
      if (expValid && outReady) begin
        if (CNT_EN && !clrCnt) begin
          if (sbQ[0].sec && ceExp < CNT_SAT) ceExp++;
          if (sbQ[0].ded && ueExp < CNT_SAT) ueExp++;
        end
        void'(sbQ.pop_front());
      end
      if (CNT_EN && clrCnt) begin
        ceExp = 0;
        ueExp = 0;
      end
      if (inValid && expReady) begin
        front     = refDecode(dataIn, eccIn);
        front.acc = cyc;
        sbQ.push_back(front);
      end
    end
  end

  // Present one codeword and hold it until the decoder takes it.
  task automatic applyStimulus(input logic [27:0] d, input logic [6:0] e);
    int   waited;
    logic acc;
    dataIn  = d;
    eccIn   = e;
    inValid = 1'b1;
    waited  = 0;
    forever begin
      acc = inReady;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 100) begin
        checkOutput("inputAcceptTimeout", 1'b0, 1'b1);
        break;
      end
    end
    inValid = 1'b0;
  endtask

  task automatic waitOut();
    int waited;
    waited = 0;
    while (!outValid) begin
      @(posedge clk);
      #1;
      waited++;
      if (waited > 100) begin
        checkOutput("outputTimeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  task automatic pinModel(input logic [27:0] d, input logic [6:0] e, input logic [27:0] xd,
                          input logic [6:0] xs, input logic xsec, input logic xded);
    beat_t r;
    r = refDecode(d, e);
    checkOutput("modelData", r.data, xd);
    checkOutput("modelSyn", r.syn, xs);
    checkOutput("modelSec", r.sec, xsec);
    checkOutput("modelDed", r.ded, xded);
  endtask

  logic [27:0] vData [6];
  logic [6:0]  vEcc  [6];
  logic [27:0] xData [6];
  logic [6:0]  xSyn  [6];
  logic        xSec  [6];
  logic        xDed  [6];

  initial begin
    int cnt;
    int idx;
    logic acc;
    logic [27:0] stallVec [4];
    logic [34:0] cw;
    int mode;

    cnt = 0;
    for (int p = 3; p < 35; p++) begin
      if ((p & (p - 1)) != 0) begin
        dataPosTb[cnt] = p;
        cnt++;
      end
    end

    // Directed vectors. data=3/ecc=0x43 has syndrome 5 with odd parity, so it
    // decodes as a single error at data1; data=3/ecc=0 is a true double error.
    vData[0] = 28'h0000001; vEcc[0] = 7'h43; xData[0] = 28'h0000001; xSyn[0] = 7'h00; xSec[0] = 0; xDed[0] = 0;
    vData[1] = 28'h0000000; vEcc[1] = 7'h43; xData[1] = 28'h0000001; xSyn[1] = 7'h43; xSec[1] = 1; xDed[1] = 0;
    vData[2] = 28'h0000003; vEcc[2] = 7'h43; xData[2] = 28'h0000001; xSyn[2] = 7'h45; xSec[2] = 1; xDed[2] = 0;
    vData[3] = 28'h0000003; vEcc[3] = 7'h00; xData[3] = 28'h0000003; xSyn[3] = 7'h06; xSec[3] = 0; xDed[3] = 1;
    vData[4] = 28'h0000000; vEcc[4] = 7'h40; xData[4] = 28'h0000000; xSyn[4] = 7'h40; xSec[4] = 1; xDed[4] = 0;
    vData[5] = 28'h0000000; vEcc[5] = 7'h7F; xData[5] = 28'h0000000; xSyn[5] = 7'h7F; xSec[5] = 0; xDed[5] = 1;

    $display("[TB] pinning reference model");
    checkOutput("modelEncode1", encode(28'h0000001), 7'h43);
    for (int i = 0; i < 6; i++) pinModel(vData[i], vEcc[i], xData[i], xSyn[i], xSec[i], xDed[i]);

    rstN = 1'b0; inValid = 1'b0; dataIn = '0; eccIn = '0; outReady = 1'b0; clrCnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstOutValid", outValid, 1'b0);
    checkOutput("rstInReady", inReady, 1'b0);
    checkOutput("rstData", dataOut, 28'h0);
    checkOutput("rstSyn", synOut, 7'h0);
    checkOutput("rstSec", secOut, 1'b0);
    checkOutput("rstDed", dedOut, 1'b0);
    checkOutput("rstCe", ceCnt, 0);
    checkOutput("rstUe", ueCnt, 0);
    rstN = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vData[i], vEcc[i]);
      waitOut();
      checkOutput("dirData", dataOut, xData[i]);
      checkOutput("dirSyn", synOut, xSyn[i]);
      checkOutput("dirSec", secOut, xSec[i]);
      checkOutput("dirDed", dedOut, xDed[i]);
      @(posedge clk);
      #1;
    end
    checkOutput("dirCeCnt", ceCnt, CNT_EN ? 3 : 0);
    checkOutput("dirUeCnt", ueCnt, CNT_EN ? 2 : 0);

    $display("[TB] back-pressure");
    for (int i = 0; i < 4; i++) begin
      stallVec[i] = 28'h1234560 + 28'(i * 7);
    end
    outReady = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      dataIn  = stallVec[idx];
      eccIn   = encode(stallVec[idx]);
      inValid = 1'b1;
      acc     = inReady;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    checkOutput("stallAccepted", idx, 2);
    checkOutput("stallInReady", inReady, 1'b0);
    checkOutput("stallHeldData", dataOut, stallVec[0]);
    outReady = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      dataIn  = stallVec[idx];
      eccIn   = encode(stallVec[idx]);
      inValid = 1'b1;
      acc     = inReady;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    inValid = 1'b0;
    checkOutput("stallAllAccepted", idx, 4);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stallDrained", sbQ.size(), 0);

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 14; i++) applyStimulus(28'h0000000, 7'h43);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ceSaturated", ceCnt, CNT_EN ? CNT_SAT : 0);
    applyStimulus(28'h0000000, 7'h40);
    waitOut();
    clrCnt = 1'b1;
    @(posedge clk);
    #1;
    clrCnt = 1'b0;
    checkOutput("ceClearPriority", ceCnt, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      mode = $urandom_range(0, 7);
      dataIn = 28'($urandom);
      cw = {encode(dataIn), dataIn};
      if (mode >= 3 && mode <= 5) cw[$urandom_range(0, 34)] ^= 1'b1;
      if (mode == 5) cw[$urandom_range(0, 34)] ^= 1'b1;
      if (mode == 6) cw = {7'($urandom), 28'($urandom)};
      dataIn   = cw[27:0];
      eccIn    = cw[34:28];
      inValid  = ($urandom_range(0, 2) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      clrCnt   = ($urandom_range(0, 31) == 0);
      rstN     = (c != 1500);
      @(posedge clk);
      #1;
    end
    rstN = 1'b1; inValid = 1'b0; clrCnt = 1'b0; outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] reset with both stages full");
    outReady = 1'b0;
    applyStimulus(28'h00000AA, encode(28'h00000AA));
    applyStimulus(28'h0000055, encode(28'h0000055));
    checkOutput("fullInReady", inReady, 1'b0);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRstOutValid", outValid, 1'b0);
    checkOutput("midRstInReady", inReady, 1'b0);
    rstN = 1'b1;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postRstOutValid", outValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
